mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multicycle MIPS-subset control unit: the sequencer that drives the ALU operand selects (ALUSrcA, ALUSrcB), ALU op and datapath enables each cycle.
- Sits between the instruction register (opcode/funct) and the datapath muxes/registers.
- Produces the ALUSrcB codes consumed by the ALU B-operand mux: 0 B, 1 const 4, 2 Shift_Left_2, 3 Sign_Extend, 4 Mem_Data.

Parameters:
- MEM_LAT, 2, memory read latency in cycles (≥1). FETCH and MEM_READ each hold for exactly MEM_LAT cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if zero.
- IorD  out  1  memory address select: 0 PC, 1 ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load.
- RegDst  out  1  0 rt, 1 rd.
- MemToReg  out  1  0 ALUOut, 1 MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  0 PC, 1 A.
- ALUSrcB  out  3  codes as in Overview.
- ALUOp  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- PCSource  out  2  0 ALU result, 1 ALUOut, 2 jump target.
- illegal  out  1  sticky illegal-instruction flag.
- state  out  4  current state, for debug.

Behaviour:
- Reset (reset=0 at clk edge):
  - state←FETCH, wait counter←0, illegal←0.
  - All strobes 0; all selects 0.
  - Reset mid-instruction aborts it; no write strobe is asserted in that cycle.
- Outputs are Moore, decoded from state and wait counter only; the exception is PCWriteCond gating, which is done in the datapath.
- FETCH:
  - Outputs: IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0.
  - Counter counts 0..MEM_LAT-1.
  - IRWrite=1 and PCWrite=1 only when counter==MEM_LAT-1; then →DECODE and counter clears.
- DECODE (1 cycle):
  - Outputs: ALUSrcA=0, ALUSrcB=2, ALUOp=ADD (branch target → ALUOut).
  - Next state by opcode: 0x00→EXEC_R; 0x08→EXEC_I; 0x23 or 0x2B→MEM_ADDR; 0x04→BRANCH; 0x02→JUMP; else→TRAP.
- EXEC_R:
  - Outputs: ALUSrcA=1, ALUSrcB=0.
  - ALUOp from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - Any other funct → TRAP, with no RegWrite issued. Valid funct → R_WB.
- R_WB: RegDst=1, MemToReg=0, RegWrite=1 → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=3, ADD → I_WB.
- I_WB: RegDst=0, MemToReg=0, RegWrite=1 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=3, ADD. Next: lw→MEM_READ, sw→MEM_WRITE.
- MEM_READ: IorD=1; counts MEM_LAT cycles like FETCH, then →MEM_WB.
- MEM_WB: RegDst=0, MemToReg=1, RegWrite=1 → FETCH.
- MEM_WRITE: IorD=1, MemWrite=1 for exactly 1 cycle → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCSource=1, PCWriteCond=1 → FETCH.
- JUMP: PCSource=2, PCWrite=1 → FETCH.
- TRAP:
  - illegal←1; all strobes 0.
  - Remains in TRAP until reset (absorbing state).
- Wait counter: width clog2(MEM_LAT)+1; cleared on every state exit. With MEM_LAT=1, FETCH lasts 1 cycle.
- Instruction cycle counts at MEM_LAT=L:
  - R-type, addi, sw: L+3.
  - lw: 2L+3.
  - beq, j: L+2.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum;
  - opcode/funct constants;
  - ALUSrcB codes (SRCB_B=0, SRCB_4=1, SRCB_SL2=2, SRCB_SEXT=3, SRCB_MEM=4);
  - ALUOp codes;
  - PCSource codes.
- One sub-module, mips_funct_dec: combinational funct→{ALUOp, valid}. It is reused by the ALU control.

Test Plan:
- Reset with reset=0 for 2 cycles, then release → state=FETCH, all strobes 0, ALUSrcB=0; cycle 1 after release shows ALUSrcB=1, ALUOp=0.
- opcode=0x00, funct=0x22, MEM_LAT=2 → DECODE at cycle 2 with ALUSrcB=2; EXEC_R with ALUSrcA=1, ALUSrcB=0, ALUOp=1; RegWrite=1 with RegDst=1 at cycle 4; FETCH at cycle 5.
- opcode=0x23 (lw) → MEM_ADDR shows ALUSrcB=3; IorD=1 held 2 cycles; MEM_WB shows MemToReg=1, RegWrite=1; total 7 cycles.
- opcode=0x04 with zero=1, then zero=0 → PCWriteCond=1, PCSource=1, ALUOp=1 for exactly one cycle in both cases.
- opcode=0x3F → TRAP, illegal=1 sticky across 10 cycles, no strobes; reset=0 clears illegal.
- reset=0 asserted during MEM_WRITE → MemWrite=0 at that edge; state=FETCH next cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control path:
// sequencer states, opcode/funct values and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_R_WB      = 4'd3,
    S_EXEC_I    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] SRCA_PC = 2'd0;
  localparam logic [1:0] SRCA_A  = 2'd1;

  localparam logic [2:0] SRCB_B    = 3'd0;
  localparam logic [2:0] SRCB_4    = 3'd1;
  localparam logic [2:0] SRCB_SL2  = 3'd2;
  localparam logic [2:0] SRCB_SEXT = 3'd3;
  localparam logic [2:0] SRCB_MEM  = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Opcodes outside the supported subset land in TRAP.
  function automatic state_e decode_opcode(input logic [5:0] op);
    case (op)
      OP_RTYPE:      decode_opcode = S_EXEC_R;
      OP_ADDI:       decode_opcode = S_EXEC_I;
      OP_LW, OP_SW:  decode_opcode = S_MEM_ADDR;
      OP_BEQ:        decode_opcode = S_BRANCH;
      OP_J:          decode_opcode = S_JUMP;
      default:       decode_opcode = S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mips_funct_dec.sv
// R-type funct field to ALU operation decoder; also used by the ALU control.
module mips_funct_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       valid_o
);

  // Map supported funct codes; anything else is flagged invalid.
  always_comb begin
    alu_op_o = ALU_ADD;
    valid_o  = 1'b1;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_SLT:  alu_op_o = ALU_SLT;
      default: begin
        alu_op_o = ALU_ADD;
        valid_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS-subset sequencer. Control outputs are registered from the
// next state, so they line up with the state register and clear on reset.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned    CW       = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic          illegal_q, illegal_d;
  logic [2:0]    fn_alu_op;
  logic          fn_valid;
  logic          unused_zero;

  // The branch decision on zero is made in the datapath via PCWriteCond.
  assign unused_zero = zero;

  mips_funct_dec u_funct_dec (
    .funct_i  (funct),
    .alu_op_o (fn_alu_op),
    .valid_o  (fn_valid)
  );

  // Next-state and wait-counter logic; the counter is zero outside memory waits.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE:   state_d = decode_opcode(opcode);
      S_EXEC_R:   state_d = fn_valid ? S_R_WB : S_TRAP;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEM_READ;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_MEM_WB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // Moore decode of the upcoming state into the control word.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.alu_src_a = SRCA_PC;
        ctrl_d.alu_src_b = SRCB_4;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.pc_source = PCS_ALU;
        if (cnt_d == CNT_LAST) begin
          ctrl_d.ir_write = 1'b1;
          ctrl_d.pc_write = 1'b1;
        end else begin
          ctrl_d.ir_write = 1'b0;
          ctrl_d.pc_write = 1'b0;
        end
      end
      S_DECODE: begin
        ctrl_d.alu_src_a = SRCA_PC;
        ctrl_d.alu_src_b = SRCB_SL2;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl_d.alu_src_a = SRCA_A;
        ctrl_d.alu_src_b = SRCB_B;
        ctrl_d.alu_op    = fn_alu_op;
      end
      S_R_WB: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl_d.alu_src_a = SRCA_A;
        ctrl_d.alu_src_b = SRCB_SEXT;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_I_WB:      ctrl_d.reg_write = 1'b1;
      S_MEM_READ:  ctrl_d.iord = 1'b1;
      S_MEM_WB: begin
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_d.iord      = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = SRCA_A;
        ctrl_d.alu_src_b     = SRCB_B;
        ctrl_d.alu_op        = ALU_SUB;
        ctrl_d.pc_source     = PCS_ALUOUT;
        ctrl_d.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_source = PCS_JUMP;
        ctrl_d.pc_write  = 1'b1;
      end
      S_TRAP:  ctrl_d = '0;
      default: ctrl_d = '0;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  // State, counter, control word and sticky illegal flag; reset aborts any instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign PCWrite     = ctrl_q.pc_write;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.iord;
  assign MemWrite    = ctrl_q.mem_write;
  assign IRWrite     = ctrl_q.ir_write;
  assign RegDst      = ctrl_q.reg_dst;
  assign MemToReg    = ctrl_q.mem_to_reg;
  assign RegWrite    = ctrl_q.reg_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign PCSource    = ctrl_q.pc_source;
  assign illegal     = illegal_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-cycle expected control words are
// queued per instruction and compared at each falling edge.
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  localparam int unsigned L = 2;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic        ill;
  } exp_t;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct  = 6'h20;
  logic       zero   = 1'b0;

  logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, illegal;
  logic [1:0] ALUSrcA, PCSource;
  logic [2:0] ALUSrcB, ALUOp;
  logic [3:0] state;

  logic       u1_PCWrite, u1_PCWriteCond, u1_IorD, u1_MemWrite, u1_IRWrite, u1_RegDst;
  logic       u1_MemToReg, u1_RegWrite, u1_illegal;
  logic [1:0] u1_ALUSrcA, u1_PCSource;
  logic [2:0] u1_ALUSrcB, u1_ALUOp;
  logic [3:0] u1_state;

  logic [17:0] obs;
  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign obs = {PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSource};

  mips_mc_ctrl #(.MEM_LAT(L)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .illegal(illegal), .state(state)
  );

  mips_mc_ctrl #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWrite(u1_PCWrite), .PCWriteCond(u1_PCWriteCond), .IorD(u1_IorD), .MemWrite(u1_MemWrite),
    .IRWrite(u1_IRWrite), .RegDst(u1_RegDst), .MemToReg(u1_MemToReg), .RegWrite(u1_RegWrite),
    .ALUSrcA(u1_ALUSrcA), .ALUSrcB(u1_ALUSrcB), .ALUOp(u1_ALUOp), .PCSource(u1_PCSource),
    .illegal(u1_illegal), .state(u1_state)
  );

  // Strobes: {PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite}
  function automatic logic [17:0] cv(input logic [7:0] stb, input logic [1:0] sa,
                                     input logic [2:0] sb, input logic [2:0] op,
                                     input logic [1:0] pcs);
    return {stb, sa, sb, op, pcs};
  endfunction

  function automatic logic [2:0] exp_aluop(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'd0;
      6'h22:   return 3'd1;
      6'h24:   return 3'd2;
      6'h25:   return 3'd3;
      6'h2A:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic [17:0] c, input logic ill);
    exp_t e;
    e.st   = st;
    e.ctrl = c;
    e.ill  = ill;
    sb_q.push_back(e);
  endtask

  task automatic push_fetch(input logic first);
    for (int k = 0; k < int'(L); k++) begin
      if (first && k == 0)
        push(S_FETCH, 18'h0, 1'b0);
      else if (k == int'(L) - 1)
        push(S_FETCH, cv(8'b1000_1000, 2'd0, 3'd1, 3'd0, 2'd0), 1'b0);
      else
        push(S_FETCH, cv(8'b0000_0000, 2'd0, 3'd1, 3'd0, 2'd0), 1'b0);
    end
  endtask

  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic first);
    push_fetch(first);
    push(S_DECODE, cv(8'b0000_0000, 2'd0, 3'd2, 3'd0, 2'd0), 1'b0);
    case (op)
      6'h00: begin
        push(S_EXEC_R, cv(8'b0000_0000, 2'd1, 3'd0, exp_aluop(fn), 2'd0), 1'b0);
        push(S_R_WB,   cv(8'b0000_0101, 2'd0, 3'd0, 3'd0, 2'd0), 1'b0);
      end
      6'h08: begin
        push(S_EXEC_I, cv(8'b0000_0000, 2'd1, 3'd3, 3'd0, 2'd0), 1'b0);
        push(S_I_WB,   cv(8'b0000_0001, 2'd0, 3'd0, 3'd0, 2'd0), 1'b0);
      end
      6'h23: begin
        push(S_MEM_ADDR, cv(8'b0000_0000, 2'd1, 3'd3, 3'd0, 2'd0), 1'b0);
        for (int k = 0; k < int'(L); k++)
          push(S_MEM_READ, cv(8'b0010_0000, 2'd0, 3'd0, 3'd0, 2'd0), 1'b0);
        push(S_MEM_WB, cv(8'b0000_0011, 2'd0, 3'd0, 3'd0, 2'd0), 1'b0);
      end
      6'h2B: begin
        push(S_MEM_ADDR,  cv(8'b0000_0000, 2'd1, 3'd3, 3'd0, 2'd0), 1'b0);
        push(S_MEM_WRITE, cv(8'b0011_0000, 2'd0, 3'd0, 3'd0, 2'd0), 1'b0);
      end
      6'h04: push(S_BRANCH, cv(8'b0100_0000, 2'd1, 3'd0, 3'd1, 2'd1), 1'b0);
      6'h02: push(S_JUMP,   cv(8'b1000_0000, 2'd0, 3'd0, 3'd0, 2'd2), 1'b0);
      default: push(S_TRAP, 18'h0, 1'b1);
    endcase
  endtask

  // Pop one expected entry per cycle and compare against the DUT outputs.
  task automatic drain(input string tag);
    exp_t e;
    int   cyc = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tests++;
      if (state !== e.st || obs !== e.ctrl || illegal !== e.ill) begin
        fails++;
        $display("FAIL %s cyc%0d: got state=%0d ctrl=%05h ill=%b, want state=%0d ctrl=%05h ill=%b",
                 tag, cyc, state, obs, illegal, e.st, e.ctrl, e.ill);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic first,
                           input string tag);
    opcode = op;
    funct  = fn;
    push_instr(op, fn, first);
    drain(tag);
  endtask

  task automatic end_fetch(input string tag);
    push(S_FETCH, cv(8'b0000_0000, 2'd0, 3'd1, 3'd0, 2'd0), 1'b0);
    drain(tag);
  endtask

  // Two reset edges, release at a falling edge: now in the first post-reset cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (state !== 4'(S_FETCH) || obs !== 18'h0 || illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got state=%0d ctrl=%05h ill=%b, want 0/00000/0", state, obs, illegal);
    end
    @(negedge clk);
    tests++;
    if (ALUSrcB !== 3'd1 || ALUOp !== 3'd0 || IRWrite !== 1'b1 || state !== 4'(S_FETCH)) begin
      fails++;
      $display("FAIL reset_cycle1: got srcb=%0d aluop=%0d irw=%b state=%0d, want 1/0/1/0",
               ALUSrcB, ALUOp, IRWrite, state);
    end
  endtask

  task automatic test_rtype();
    do_reset();
    run_instr(6'h00, 6'h22, 1'b1, "rtype_sub");
    run_instr(6'h00, 6'h20, 1'b0, "rtype_add");
    run_instr(6'h00, 6'h24, 1'b0, "rtype_and");
    run_instr(6'h00, 6'h25, 1'b0, "rtype_or");
    run_instr(6'h00, 6'h2A, 1'b0, "rtype_slt");
    end_fetch("rtype_end");
  endtask

  task automatic test_itype_jump();
    do_reset();
    run_instr(6'h08, 6'h00, 1'b1, "addi");
    run_instr(6'h02, 6'h00, 1'b0, "jump");
    end_fetch("itype_end");
  endtask

  task automatic test_back_to_back_mem();
    do_reset();
    run_instr(6'h23, 6'h00, 1'b1, "lw");
    run_instr(6'h2B, 6'h00, 1'b0, "sw");
    run_instr(6'h23, 6'h00, 1'b0, "lw2");
    end_fetch("mem_end");
  endtask

  task automatic test_branch();
    do_reset();
    zero = 1'b1;
    run_instr(6'h04, 6'h00, 1'b1, "beq_z1");
    zero = 1'b0;
    run_instr(6'h04, 6'h00, 1'b0, "beq_z0");
    end_fetch("beq_end");
  endtask

  task automatic test_trap();
    logic rw_seen;
    do_reset();
    run_instr(6'h3F, 6'h00, 1'b1, "trap_op");
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (illegal !== 1'b1 || state !== 4'(S_TRAP) || obs !== 18'h0) begin
        fails++;
        $display("FAIL trap_sticky c%0d: got ill=%b state=%0d ctrl=%05h, want 1/%0d/00000",
                 i, illegal, state, obs, S_TRAP);
      end
      @(negedge clk);
    end
    do_reset();
    tests++;
    if (illegal !== 1'b0 || state !== 4'(S_FETCH)) begin
      fails++;
      $display("FAIL trap_clear: got ill=%b state=%0d, want 0/0", illegal, state);
    end
    opcode  = 6'h00;
    funct   = 6'h3F;
    rw_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rw_seen = rw_seen | RegWrite;
      @(negedge clk);
    end
    tests++;
    if (rw_seen !== 1'b0 || state !== 4'(S_TRAP) || illegal !== 1'b1) begin
      fails++;
      $display("FAIL bad_funct: got regwrite_seen=%b state=%0d ill=%b, want 0/%0d/1",
               rw_seen, state, illegal, S_TRAP);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = 6'h2B;
    push_fetch(1'b1);
    push(S_DECODE,   cv(8'b0000_0000, 2'd0, 3'd2, 3'd0, 2'd0), 1'b0);
    push(S_MEM_ADDR, cv(8'b0000_0000, 2'd1, 3'd3, 3'd0, 2'd0), 1'b0);
    drain("mid_pre");
    tests++;
    if (MemWrite !== 1'b1 || state !== 4'(S_MEM_WRITE)) begin
      fails++;
      $display("FAIL mid_memwrite: got mw=%b state=%0d, want 1/%0d", MemWrite, state, S_MEM_WRITE);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (MemWrite !== 1'b0 || state !== 4'(S_FETCH) || obs !== 18'h0) begin
      fails++;
      $display("FAIL mid_abort: got mw=%b state=%0d ctrl=%05h, want 0/0/00000", MemWrite, state, obs);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (state !== 4'(S_FETCH) || IRWrite !== 1'b1 || ALUSrcB !== 3'd1) begin
      fails++;
      $display("FAIL mid_restart: got state=%0d irw=%b srcb=%0d, want 0/1/1", state, IRWrite, ALUSrcB);
    end
  endtask

  task automatic test_lat1();
    logic [3:0] st_exp [6];
    logic       io_exp [6];
    st_exp = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_FETCH};
    io_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    opcode = 6'h23;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (u1_state !== st_exp[i] || u1_IorD !== io_exp[i]) begin
        fails++;
        $display("FAIL lat1 c%0d: got state=%0d iord=%b, want %0d/%b",
                 i, u1_state, u1_IorD, st_exp[i], io_exp[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype_jump();
    test_back_to_back_mem();
    test_branch();
    test_trap();
    test_reset_mid();
    test_lat1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
